cfg_readback_tx: RTL and testbench

CFG_READBACK_TX -- requirements
Module: cfg_readback_tx

---
 rtl/cfg_readback_pkg.sv | 16 +
 rtl/piso_shifter.sv | 58 +++++
 rtl/cfg_readback_tx.sv | 107 ++++++++++
 tb/tb_cfg_readback_tx.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_readback_pkg.sv
// Shared types and constants for the configuration readback serializer.
// CFG_READBACK_PARITY_EN adds a trailing even-parity bit state (ST_PAR).
package cfg_readback_pkg;

    localparam int CFG_READBACK_DEFAULT_N = 79;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
`ifdef CFG_READBACK_PARITY_EN
        ST_PAR   = 2'd2,
`endif
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/piso_shifter.sv
// Parallel-in serial-out datapath: MSB-first shift register, bit counter and
// (with CFG_READBACK_PARITY_EN) the parity of the captured word.
module piso_shifter
    import cfg_readback_pkg::*;
#(
    parameter int N  = CFG_READBACK_DEFAULT_N,
    localparam int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_advance,
    input  logic [N-1:0] i_par,
    output logic         o_msb,
`ifdef CFG_READBACK_PARITY_EN
    output logic         o_parity,
`endif
    output logic         o_cnt_zero
);

    logic [N-1:0]  r_sreg;
    logic [CW-1:0] r_cnt;
    logic          w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    // Advancing is refused at zero so the counter can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_sreg <= i_par;
            r_cnt  <= CW'(N - 1);
        end else if (i_advance && !w_cnt_zero) begin
            r_sreg <= {r_sreg[N-2:0], 1'b0};
            r_cnt  <= r_cnt - CW'(1);
        end
    end

`ifdef CFG_READBACK_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (i_load) begin
            r_parity <= ^i_par;
        end
    end

    assign o_parity = r_parity;
`endif

    assign o_msb      = r_sreg[N-1];
    assign o_cnt_zero = w_cnt_zero;

endmodule

// File: rtl/cfg_readback_tx.sv
// Captures a status/config word on start and streams it out MSB first under
// shift_en flow control. CFG_READBACK_PARITY_EN appends an even-parity bit.
module cfg_readback_tx
    import cfg_readback_pkg::*;
#(
    parameter int N = CFG_READBACK_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         shift_en,
    input  logic [N-1:0] par_in,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         busy,
    output logic         done
);

    state_e r_state;
    state_e w_next;
    logic   w_load;
    logic   w_advance;
    logic   w_msb;
    logic   w_cnt_zero;

    // Capture is only possible between frames; a shift_en in that cycle is not a consume.
    assign w_load    = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
    assign w_advance = (r_state == ST_SHIFT) && shift_en;

`ifdef CFG_READBACK_PARITY_EN
    logic w_parity;
`endif

    piso_shifter #(
        .N (N)
    ) u_piso (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_advance  (w_advance),
        .i_par      (par_in),
        .o_msb      (w_msb),
`ifdef CFG_READBACK_PARITY_EN
        .o_parity   (w_parity),
`endif
        .o_cnt_zero (w_cnt_zero)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (shift_en && w_cnt_zero) begin
`ifdef CFG_READBACK_PARITY_EN
                    w_next = ST_PAR;
`else
                    w_next = ST_DONE;
`endif
                end
            end
`ifdef CFG_READBACK_PARITY_EN
            ST_PAR: begin
                if (shift_en) w_next = ST_DONE;
            end
`endif
            ST_DONE: begin
                w_next = start ? ST_SHIFT : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs decode straight from registered state, so reset clears them the same edge.
    always_comb begin
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        busy      = 1'b0;
        done      = (r_state == ST_DONE);
        case (r_state)
            ST_SHIFT: begin
                ser_out   = w_msb;
                ser_valid = 1'b1;
                busy      = 1'b1;
            end
`ifdef CFG_READBACK_PARITY_EN
            ST_PAR: begin
                ser_out   = w_parity;
                ser_valid = 1'b1;
                busy      = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cfg_readback_tx.sv
// Directed bench for cfg_readback_tx at N=8; honours CFG_READBACK_PARITY_EN.
module tb_cfg_readback_tx;
    import cfg_readback_pkg::*;

    localparam int N = 8;
`ifdef CFG_READBACK_PARITY_EN
    localparam int FRAME = N + 1;
`else
    localparam int FRAME = N;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic         shift_en;
    logic [N-1:0] par_in;
    logic         ser_out;
    logic         ser_valid;
    logic         busy;
    logic         done;

    int total;
    int bad;

    cfg_readback_tx #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .shift_en  (shift_en),
        .par_in    (par_in),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; shift_en = 1'b1; par_in = 8'hFF;
        tick; tick;
        total++;
        if ({ser_out, ser_valid, busy, done} !== 4'b0000 || dut.r_state !== ST_IDLE) begin
            bad++;
            $display("FAIL reset outs=%b state=%0d expected 0000 state 0",
                     {ser_out, ser_valid, busy, done}, dut.r_state);
        end
        rst = 1'b0; start = 1'b0; shift_en = 1'b0;
        tick;
        total++;
        if ({ser_valid, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_idle outs=%b expected 000", {ser_valid, busy, done});
        end
    endtask

    task automatic test_basic;
        logic [N-1:0] w;
        int busy_cnt;
        w = 8'hA5; busy_cnt = 0;
        par_in = w; start = 1'b1; shift_en = 1'b1;
        tick;
        start = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            total++;
            if (ser_out !== w[i] || ser_valid !== 1'b1) begin
                bad++;
                $display("FAIL basic_bit%0d ser_out=%b valid=%b expected %b 1", i, ser_out, ser_valid, w[i]);
            end
            if (busy === 1'b1) busy_cnt++;
            tick;
        end
`ifdef CFG_READBACK_PARITY_EN
        if (busy === 1'b1) busy_cnt++;
        tick;
`endif
        total++;
        if ({done, busy, ser_valid, ser_out} !== 4'b1000) begin
            bad++;
            $display("FAIL basic_done done/busy/valid/out=%b expected 1000", {done, busy, ser_valid, ser_out});
        end
        total++;
        if (busy_cnt != FRAME) begin
            bad++;
            $display("FAIL basic_busy_len got %0d expected %0d", busy_cnt, FRAME);
        end
        tick;
        total++;
        if (done !== 1'b0 || dut.r_state !== ST_IDLE) begin
            bad++;
            $display("FAIL basic_after done=%b state=%0d expected 0 IDLE", done, dut.r_state);
        end
    endtask

    task automatic test_stall;
        logic [N-1:0] w;
        int cyc;
        w = 8'hF0; cyc = 0;
        par_in = w; start = 1'b1; shift_en = 1'b1;
        tick;
        start = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            total++;
            if (ser_out !== w[i] || ser_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_bit%0d ser_out=%b valid=%b expected %b 1", i, ser_out, ser_valid, w[i]);
            end
            if (i == 5) begin
                shift_en = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick; cyc++;
                    total++;
                    if (ser_out !== 1'b1 || ser_valid !== 1'b1 || busy !== 1'b1) begin
                        bad++;
                        $display("FAIL stall_hold%0d ser_out=%b valid=%b busy=%b expected 1 1 1",
                                 s, ser_out, ser_valid, busy);
                    end
                end
                shift_en = 1'b1;
            end
            tick; cyc++;
        end
`ifdef CFG_READBACK_PARITY_EN
        tick; cyc++;
`endif
        total++;
        if (done !== 1'b1 || cyc != FRAME + 5) begin
            bad++;
            $display("FAIL stall_done done=%b cycles=%0d expected 1 %0d", done, cyc, FRAME + 5);
        end
        tick;
    endtask

    task automatic test_ignore_start;
        logic [N-1:0] w;
        w = 8'hA5;
        par_in = w; start = 1'b1; shift_en = 1'b1;
        tick;
        start = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            total++;
            if (ser_out !== w[i]) begin
                bad++;
                $display("FAIL ignore_bit%0d ser_out=%b expected %b", i, ser_out, w[i]);
            end
            start  = (i <= 6 && i >= 2);
            par_in = 8'h00;
            tick;
        end
        start = 1'b0;
`ifdef CFG_READBACK_PARITY_EN
        total++;
        if (ser_out !== ^w) begin
            bad++;
            $display("FAIL ignore_parity ser_out=%b expected %b", ser_out, ^w);
        end
        tick;
`endif
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL ignore_done done=%b expected 1", done);
        end
        tick;
    endtask

    task automatic test_rst_mid;
        logic [N-1:0] w;
        w = 8'hA5;
        par_in = w; start = 1'b1; shift_en = 1'b1;
        tick;
        start = 1'b0;
        for (int i = N - 1; i >= 4; i--) begin
            if (i > 4) tick;
        end
        total++;
        if (ser_out !== w[4] || busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre ser_out=%b busy=%b expected %b 1", ser_out, busy, w[4]);
        end
        rst = 1'b1; start = 1'b1;
        tick;
        rst = 1'b0; start = 1'b0;
        total++;
        if ({ser_out, ser_valid, busy, done} !== 4'b0000 || dut.r_state !== ST_IDLE) begin
            bad++;
            $display("FAIL rst_mid outs=%b state=%0d expected 0000 IDLE",
                     {ser_out, ser_valid, busy, done}, dut.r_state);
        end
        for (int k = 0; k < 3; k++) begin
            tick;
            total++;
            if ({ser_valid, busy, done} !== 3'b000) begin
                bad++;
                $display("FAIL rst_after%0d valid/busy/done=%b expected 000", k, {ser_valid, busy, done});
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] w;
        logic [N-1:0] w2;
        w = 8'hA5; w2 = 8'h3C;
        par_in = w; start = 1'b1; shift_en = 1'b1;
        tick;
        start = 1'b0;
        for (int i = N - 1; i >= 0; i--) tick;
`ifdef CFG_READBACK_PARITY_EN
        tick;
`endif
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done1 done=%b expected 1", done);
        end
        start = 1'b1; par_in = w2;
        tick;
        start = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            total++;
            if (ser_out !== w2[i] || ser_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL b2b_bit%0d out/valid/busy/done=%b expected %b110", i,
                         {ser_out, ser_valid, busy, done}, w2[i]);
            end
            tick;
        end
`ifdef CFG_READBACK_PARITY_EN
        tick;
`endif
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done2 done=%b expected 1", done);
        end
        tick;
    endtask

`ifdef CFG_READBACK_PARITY_EN
    task automatic test_parity;
        logic [N-1:0] words [2];
        logic         exp_par [2];
        words[0] = 8'h07; exp_par[0] = 1'b1;
        words[1] = 8'h03; exp_par[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            par_in = words[t]; start = 1'b1; shift_en = 1'b1;
            tick;
            start = 1'b0;
            for (int i = N - 1; i >= 0; i--) tick;
            total++;
            if (ser_out !== exp_par[t] || ser_valid !== 1'b1 || busy !== 1'b1) begin
                bad++;
                $display("FAIL parity_%0d out/valid/busy=%b expected %b11", t,
                         {ser_out, ser_valid, busy}, exp_par[t]);
            end
            shift_en = 1'b0;
            tick;
            total++;
            if (ser_out !== exp_par[t] || ser_valid !== 1'b1) begin
                bad++;
                $display("FAIL parity_stall_%0d out=%b expected %b", t, ser_out, exp_par[t]);
            end
            shift_en = 1'b1;
            tick;
            total++;
            if (done !== 1'b1 || ser_valid !== 1'b0) begin
                bad++;
                $display("FAIL parity_done_%0d done=%b valid=%b expected 1 0", t, done, ser_valid);
            end
            tick;
        end
    endtask
`endif

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; shift_en = 1'b0; par_in = '0;
        test_reset;
        test_basic;
        test_stall;
        test_ignore_start;
        test_rst_mid;
        test_back_to_back;
`ifdef CFG_READBACK_PARITY_EN
        test_parity;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
